vga_entity_renderer: RTL and testbench
======================================

Name: vga_entity_renderer

Overview:
- Display-side consumer of the game entity bus: ship, enemy row, allied shot and enemy shot positions.
- Generates 640x480@60 VGA timing from CLOCK_50 using a divide-by-2 pixel enable.
- Snapshots entity positions once per frame, at vblank start, so sprites never tear mid-frame.
- Rasterises each pixel through a fixed-latency pipeline into 24-bit RGB; sits between the entity logic and the board DAC.

Parameters:
- NAVE_W, 45: ship width in pixels.
- NAVE_H, 20: ship height in pixels.
- INIM_W, 30: enemy width in pixels.
- INIM_H, 20: enemy height in pixels.
- COR_FUNDO, 24'h000000: background colour.
- COR_NAVE, 24'h00FF00: ship colour.
- COR_INIM, 24'hFF00FF: enemy colour.
- COR_BOLA_A, 24'hFFFFFF: allied shot colour.
- COR_BOLA_I, 24'hFF0000: enemy shot colour.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- x_nave  in  10  ship top-left x.
- y_nave  in  10  ship top-left y.
- x_bola_aliada  in  10  allied shot centre x.
- y_bola_aliada  in  10  allied shot centre y.
- raio_bola_aliada  in  10  allied shot radius; 0 = hidden.
- x_bola_inimiga  in  10  enemy shot centre x.
- y_bola_inimiga  in  10  enemy shot centre y.
- raio_bola_inimiga  in  10  enemy shot radius; 0 = hidden.
- inimigo_x  in  50  5 x 10-bit enemy top-left x; enemy k at bits [10k+9:10k].
- inimigo_y  in  50  5 x 10-bit enemy top-left y, same packing.
- inimigo_vivo  in  5  bit k = enemy k alive.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.
- vga_hs  out  1  hsync, active low.
- vga_vs  out  1  vsync, active low.
- vga_blank_n  out  1  high during the visible area.
- vga_clk  out  1  copy of the pixel enable, for the DAC.

Behaviour:
- Pixel enable pix_en:
  - Register toggling every CLOCK_50 cycle; reset to 0.
  - First high on the 2nd cycle after reset deasserts.
  - All counters and pipeline stages advance only when pix_en = 1.
- Counters:
  - h_cnt runs 0..799; wraps to 0 and increments v_cnt.
  - v_cnt runs 0..524; wraps to 0.
  - Both reset to 0.
- Raw timing, derived from counters:
  - visible = h<640 && v<480.
  - hs_raw low for h in 656..751.
  - vs_raw low for v in 490..491.
- Snapshot:
  - On the pix_en tick where h_cnt=0 && v_cnt=480, all entity inputs load into shadow registers.
  - Rendering uses only the shadow copies, so input changes take effect from the next displayed frame.
  - Shadow reset values: all positions 0, raios 0, vivo 0, so only the ship at (0,0) is drawn after reset.
- Pipeline: 3 pix_en ticks from counter value to outputs.
  - S1: register h, v, visible, hs_raw, vs_raw.
  - S2: compute hit flags from S1 coordinates.
    - Ship hit: x_nave <= h < x_nave+NAVE_W and y_nave <= v < y_nave+NAVE_H. Use 11-bit sums; no wrap.
    - Enemy k hit: vivo[k] and the rectangle test with INIM_W/INIM_H.
    - Shot hit: raio != 0 and dx*dx + dy*dy <= raio*raio.
      - dx = h-x, dy = v-y, 11-bit signed.
      - Squares and sum are 22-bit unsigned; compare at full width, no truncation.
  - S3: register colour and timing outputs.
    - Colour priority: enemy shot > allied shot > ship > any enemy > COR_FUNDO.
    - When visible=0, RGB is forced to 0.
    - vga_hs, vga_vs and vga_blank_n come from the S2-delayed raw signals, so sync stays aligned with the pixel data.
- Output reset values:
  - rgb = 0.
  - vga_hs = 1, vga_vs = 1.
  - vga_blank_n = 0, vga_clk = 0.
  - All pipeline registers cleared.
- Reset mid-frame: counters restart at (0,0) and the pipeline flushes. The first valid pixel appears 3 ticks after the first pix_en.
- Boundaries:
  - Sprites partially off-screen are clipped naturally; no wrap to the left edge.
  - Shot centres near 0 use signed dx/dy; no unsigned underflow.

Test Plan:
- Reset, then run 10 cycles -> rgb=0, hs=vs=1, blank_n=0 while reset is high; vga_clk toggles after release.
- Free-run 2 frames -> hs low for exactly 96 pix_en ticks per line; line period is 1600 CLOCK_50 cycles; vs low for 2 lines; frame period is 840000 CLOCK_50 cycles; blank_n high for 640x480 pixels per frame.
- Ship at (100,200) -> at S3 output, pixel (100,200) and (144,219) are COR_NAVE; (145,200) and (100,220) are COR_FUNDO.
- Change x_nave 100->300 at v=100 -> rest of current frame still drawn at 100; next frame drawn at 300.
- Allied shot at (100,100), raio 5 -> (103,104) lit (25<=25); (104,104) dark (32>25); raio 0 -> no pixel lit.
- Enemy 2 at (200,50) with vivo=5'b00100; enemy shot at (210,60), raio 3 -> (210,60) is COR_BOLA_I, (200,50) is COR_INIM; clear vivo[2] -> (200,50) is COR_FUNDO next frame.

Source files
------------

// File: rtl/vga_entity_renderer.sv
// VGA renderer for the game entity bus: per-frame snapshot of entity positions,
// a 3-tick pixel pipeline, and 24-bit RGB plus sync for the board DAC.
module vga_entity_renderer #(
    parameter int          NAVE_W     = 45,
    parameter int          NAVE_H     = 20,
    parameter int          INIM_W     = 30,
    parameter int          INIM_H     = 20,
    parameter logic [23:0] COR_FUNDO  = 24'h000000,
    parameter logic [23:0] COR_NAVE   = 24'h00FF00,
    parameter logic [23:0] COR_INIM   = 24'hFF00FF,
    parameter logic [23:0] COR_BOLA_A = 24'hFFFFFF,
    parameter logic [23:0] COR_BOLA_I = 24'hFF0000,
    parameter int          H_VISIBLE  = 640,
    parameter int          H_FRONT    = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BACK     = 48,
    parameter int          V_VISIBLE  = 480,
    parameter int          V_FRONT    = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BACK     = 33
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [9:0]  x_nave,
    input  logic [9:0]  y_nave,
    input  logic [9:0]  x_bola_aliada,
    input  logic [9:0]  y_bola_aliada,
    input  logic [9:0]  raio_bola_aliada,
    input  logic [9:0]  x_bola_inimiga,
    input  logic [9:0]  y_bola_inimiga,
    input  logic [9:0]  raio_bola_inimiga,
    input  logic [49:0] inimigo_x,
    input  logic [49:0] inimigo_y,
    input  logic [4:0]  inimigo_vivo,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk
);
    localparam logic [9:0]  H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0]  HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] NW     = 11'(NAVE_W);
    localparam logic [10:0] NH     = 11'(NAVE_H);
    localparam logic [10:0] IW     = 11'(INIM_W);
    localparam logic [10:0] IH     = 11'(INIM_H);

    logic       pix_en;
    logic [9:0] h_cnt, v_cnt;
    logic       snapshot;

    always_ff @(posedge CLOCK_50) begin
        if (reset) pix_en <= 1'b0;
        else       pix_en <= ~pix_en;
    end
    assign vga_clk = pix_en;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Entity positions are latched once per frame at vblank start to avoid tearing.
    logic [9:0]  sh_x_nave, sh_y_nave, sh_x_ba, sh_y_ba, sh_r_ba, sh_x_bi, sh_y_bi, sh_r_bi;
    logic [49:0] sh_inim_x, sh_inim_y;
    logic [4:0]  sh_vivo;

    assign snapshot = pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sh_x_nave <= '0; sh_y_nave <= '0;
            sh_x_ba   <= '0; sh_y_ba   <= '0; sh_r_ba <= '0;
            sh_x_bi   <= '0; sh_y_bi   <= '0; sh_r_bi <= '0;
            sh_inim_x <= '0; sh_inim_y <= '0; sh_vivo <= '0;
        end else if (snapshot) begin
            sh_x_nave <= x_nave;          sh_y_nave <= y_nave;
            sh_x_ba   <= x_bola_aliada;   sh_y_ba   <= y_bola_aliada;   sh_r_ba <= raio_bola_aliada;
            sh_x_bi   <= x_bola_inimiga;  sh_y_bi   <= y_bola_inimiga;  sh_r_bi <= raio_bola_inimiga;
            sh_inim_x <= inimigo_x;       sh_inim_y <= inimigo_y;       sh_vivo <= inimigo_vivo;
        end
    end

    logic [9:0] s1_h, s1_v;
    logic       s1_vis, s1_hs, s1_vs;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s1_h <= '0; s1_v <= '0;
            s1_vis <= 1'b0; s1_hs <= 1'b0; s1_vs <= 1'b0;
        end else if (pix_en) begin
            s1_h   <= h_cnt;
            s1_v   <= v_cnt;
            s1_vis <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            s1_hs  <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
            s1_vs  <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
        end
    end

    // 11-bit bounds so sprites near 1023 clip at the right edge instead of wrapping.
    function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] rx, input logic [9:0] ry,
                                     input logic [10:0] w, input logic [10:0] hgt);
        logic [10:0] px11, py11, rx11, ry11;
        px11 = {1'b0, px};
        py11 = {1'b0, py};
        rx11 = {1'b0, rx};
        ry11 = {1'b0, ry};
        return (px11 >= rx11) && (px11 < rx11 + w) && (py11 >= ry11) && (py11 < ry11 + hgt);
    endfunction

    function automatic logic shot_hit(input logic [9:0] px, input logic [9:0] py,
                                      input logic [9:0] cx, input logic [9:0] cy,
                                      input logic [9:0] r);
        logic signed [10:0] dx, dy;
        logic signed [21:0] dxw, dyw;
        logic [21:0]        d2, r2;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        dxw = dx;
        dyw = dy;
        d2  = $unsigned(dxw * dxw) + $unsigned(dyw * dyw);
        r2  = {12'd0, r} * {12'd0, r};
        return (r != 10'd0) && (d2 <= r2);
    endfunction

    logic hit_nave, hit_inim, hit_ba, hit_bi;

    always_comb begin
        hit_inim = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (sh_vivo[k] && in_rect(s1_h, s1_v, sh_inim_x[10*k +: 10], sh_inim_y[10*k +: 10], IW, IH))
                hit_inim = 1'b1;
        end
    end

    assign hit_nave = in_rect(s1_h, s1_v, sh_x_nave, sh_y_nave, NW, NH);
    assign hit_ba   = shot_hit(s1_h, s1_v, sh_x_ba, sh_y_ba, sh_r_ba);
    assign hit_bi   = shot_hit(s1_h, s1_v, sh_x_bi, sh_y_bi, sh_r_bi);

    logic s2_nave, s2_inim, s2_ba, s2_bi, s2_vis, s2_hs, s2_vs;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            s2_nave <= 1'b0; s2_inim <= 1'b0; s2_ba <= 1'b0; s2_bi <= 1'b0;
            s2_vis  <= 1'b0; s2_hs   <= 1'b0; s2_vs <= 1'b0;
        end else if (pix_en) begin
            s2_nave <= hit_nave; s2_inim <= hit_inim; s2_ba <= hit_ba; s2_bi <= hit_bi;
            s2_vis  <= s1_vis;   s2_hs   <= s1_hs;    s2_vs <= s1_vs;
        end
    end

    logic [23:0] rgb_next;

    always_comb begin
        rgb_next = COR_FUNDO;
        if (!s2_vis)      rgb_next = 24'h000000;
        else if (s2_bi)   rgb_next = COR_BOLA_I;
        else if (s2_ba)   rgb_next = COR_BOLA_A;
        else if (s2_nave) rgb_next = COR_NAVE;
        else if (s2_inim) rgb_next = COR_INIM;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= 24'h000000;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_en) begin
            {vga_r, vga_g, vga_b} <= rgb_next;
            vga_hs      <= ~s2_hs;
            vga_vs      <= ~s2_vs;
            vga_blank_n <= s2_vis;
        end
    end
endmodule

// File: tb/tb_vga_entity_renderer.sv
// Bench for vga_entity_renderer on a shrunken raster (80x44 visible) so several
// frames fit in a short run; spot checks plus a full-frame reference comparison.
module tb_vga_entity_renderer;
  localparam int HV = 80, HF = 2, HSY = 4, HB = 2;
  localparam int VV = 44, VF = 2, VSY = 2, VB = 1;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam logic [23:0] C_FUNDO = 24'h000000, C_NAVE = 24'h00FF00, C_INIM = 24'hFF00FF;
  localparam logic [23:0] C_BA = 24'hFFFFFF, C_BI = 24'hFF0000;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [9:0] x_nave = '0, y_nave = '0, x_bola_aliada = '0, y_bola_aliada = '0, raio_bola_aliada = '0;
  logic [9:0] x_bola_inimiga = '0, y_bola_inimiga = '0, raio_bola_inimiga = '0;
  logic [49:0] inimigo_x = '0, inimigo_y = '0;
  logic [4:0] inimigo_vivo = '0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, vga_clk;
  logic [23:0] rgb;
  assign rgb = {vga_r, vga_g, vga_b};

  vga_entity_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .x_nave(x_nave), .y_nave(y_nave),
    .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada), .raio_bola_aliada(raio_bola_aliada),
    .x_bola_inimiga(x_bola_inimiga), .y_bola_inimiga(y_bola_inimiga), .raio_bola_inimiga(raio_bola_inimiga),
    .inimigo_x(inimigo_x), .inimigo_y(inimigo_y), .inimigo_vivo(inimigo_vivo),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_clk(vga_clk)
  );

  // clock / cycle counter
  always #10 CLOCK_50 = ~CLOCK_50;
  longint cyc = 0, last_vs_fall = 0, prev_vs_fall = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge vga_vs) begin
    prev_vs_fall = last_vs_fall;
    last_vs_fall = cyc;
  end

  int checks = 0, errors = 0, tick = 0;
  bit ticked = 0, stalled = 0;

  // reference model: entity state as shown in the current frame
  int m_xn, m_yn, m_xa, m_ya, m_ra, m_xi, m_yi, m_ri;
  int m_ex[5], m_ey[5];
  logic [4:0] m_vivo;

  task automatic model_clear();
    m_xn = 0; m_yn = 0; m_xa = 0; m_ya = 0; m_ra = 0; m_xi = 0; m_yi = 0; m_ri = 0;
    for (int k = 0; k < 5; k++) begin m_ex[k] = 0; m_ey[k] = 0; end
    m_vivo = '0;
  endtask

  task automatic take_snapshot();
    m_xn = x_nave; m_yn = y_nave;
    m_xa = x_bola_aliada; m_ya = y_bola_aliada; m_ra = raio_bola_aliada;
    m_xi = x_bola_inimiga; m_yi = y_bola_inimiga; m_ri = raio_bola_inimiga;
    for (int k = 0; k < 5; k++) begin m_ex[k] = inimigo_x[10*k +: 10]; m_ey[k] = inimigo_y[10*k +: 10]; end
    m_vivo = inimigo_vivo;
  endtask

  function automatic logic [23:0] model_rgb(input int h, input int v);
    if (!(h < HV && v < VV)) return 24'h000000;
    if (m_ri != 0 && (h - m_xi) * (h - m_xi) + (v - m_yi) * (v - m_yi) <= m_ri * m_ri) return C_BI;
    if (m_ra != 0 && (h - m_xa) * (h - m_xa) + (v - m_ya) * (v - m_ya) <= m_ra * m_ra) return C_BA;
    if (h >= m_xn && h < m_xn + 45 && v >= m_yn && v < m_yn + 20) return C_NAVE;
    for (int k = 0; k < 5; k++)
      if (m_vivo[k] && h >= m_ex[k] && h < m_ex[k] + 30 && v >= m_ey[k] && v < m_ey[k] + 20) return C_INIM;
    return C_FUNDO;
  endfunction

  // drivers: one CLOCK_50 cycle; 'tick' counts pixel-enable edges since reset release,
  // so after a tick the outputs show pixel (tick-3) of the raster.
  task automatic step();
    logic en;
    @(negedge CLOCK_50);
    en = vga_clk;
    @(posedge CLOCK_50);
    #1;
    ticked = (en === 1'b1) && !reset;
    if (ticked) begin
      if (tick % HT == 0 && (tick / HT) % VT == VV) take_snapshot();
      tick++;
    end
  endtask

  task automatic next_tick(output bit ok);
    ok = 0;
    for (int n = 0; n < 4 && !ok; n++) begin step(); ok = ticked; end
    if (!ok && !stalled) begin
      stalled = 1; checks++; errors++;
      $display("FAIL pix_en_stall: vga_clk did not pulse within 4 cycles (tick=%0d)", tick);
    end
  endtask

  task automatic wait_px(input int h, input int v);
    bit hit = 0;
    if (stalled) return;
    for (int n = 0; n < 4 * HT * VT + 16 && !hit; n++) begin
      step();
      hit = ticked && tick >= 3 && ((tick - 3) % HT == h) && (((tick - 3) / HT) % VT == v);
    end
    if (!hit) begin
      stalled = 1; checks++; errors++;
      $display("FAIL wait_px(%0d,%0d): pixel never reached on output", h, v);
    end
  endtask

  function automatic logic [9:0] rnd(input int hi);
    if ($urandom_range(0, 7) == 0) return 10'($urandom_range(990, 1023));
    return 10'($urandom_range(0, hi));
  endfunction

  task automatic set_random_inputs();
    x_nave = rnd(95); y_nave = rnd(55);
    x_bola_aliada = rnd(95); y_bola_aliada = rnd(55); raio_bola_aliada = 10'($urandom_range(0, 12));
    x_bola_inimiga = rnd(95); y_bola_inimiga = rnd(55); raio_bola_inimiga = 10'($urandom_range(0, 12));
    for (int k = 0; k < 5; k++) begin inimigo_x[10*k +: 10] = rnd(95); inimigo_y[10*k +: 10] = rnd(55); end
    inimigo_vivo = 5'($urandom_range(0, 31));
  endtask

  // checks across release: flush latency and first pixel
  task automatic release_and_flush(input string name);
    bit ok;
    int flush_bad = 0, toggle_bad = 0;
    logic prev_clk;
    reset = 1'b0;
    tick = 0;
    model_clear();
    prev_clk = vga_clk;
    while (tick < 3 && !stalled) begin
      step();
      if (vga_clk === prev_clk) toggle_bad++;
      prev_clk = vga_clk;
      if (tick < 3 && (rgb !== 24'h0 || vga_blank_n !== 1'b0 || vga_hs !== 1'b1 || vga_vs !== 1'b1)) flush_bad++;
      if (!ticked && tick == 0 && toggle_bad > 3) begin next_tick(ok); end
    end
    checks++; if (toggle_bad != 0) begin errors++; $display("FAIL %s_vga_clk_toggle: %0d non-toggling cycles, required 0", name, toggle_bad); end
    checks++; if (flush_bad != 0) begin errors++; $display("FAIL %s_flush: %0d cycles with non-reset outputs before tick 3, required 0", name, flush_bad); end
    checks++; if ({rgb, vga_blank_n} !== {C_NAVE, 1'b1}) begin errors++; $display("FAIL %s_first_pixel: rgb=%06h blank_n=%b, required %06h 1", name, rgb, vga_blank_n, C_NAVE); end
  endtask

  task automatic test_reset();
    int clk_bad = 0;
    repeat (10) begin step(); if (vga_clk !== 1'b0) clk_bad++; end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: rgb=%06h required 000000", rgb); end
    checks++; if ({vga_hs, vga_vs} !== 2'b11) begin errors++; $display("FAIL reset_sync: hs=%b vs=%b required 1 1", vga_hs, vga_vs); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank: blank_n=%b required 0", vga_blank_n); end
    checks++; if (clk_bad != 0) begin errors++; $display("FAIL reset_vga_clk: %0d cycles high during reset, required 0", clk_bad); end
    x_nave = 10'd10; y_nave = 10'd20;
    release_and_flush("reset");
  endtask

  // frame 0: sync widths, line period, blanking area
  task automatic test_timing();
    int line_hs = 0, vs_ticks = 0, blank_cnt = 0, falls = 0;
    longint fall0 = 0, fall1 = 0;
    logic prev_hs;
    bit ok;
    prev_hs = vga_hs;
    for (int p = 0; p < HT * VT && !stalled; p++) begin
      if (vga_hs === 1'b0) line_hs++;
      if (vga_vs === 1'b0) vs_ticks++;
      if (vga_blank_n === 1'b1) blank_cnt++;
      if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
        if (falls == 0) fall0 = cyc; else if (falls == 1) fall1 = cyc;
        falls++;
      end
      prev_hs = vga_hs;
      if (p % HT == HT - 1) begin
        checks++; if (line_hs != HSY) begin errors++; $display("FAIL hs_width line %0d: %0d low ticks, required %0d", p / HT, line_hs, HSY); end
        line_hs = 0;
      end
      next_tick(ok);
    end
    checks++; if (fall1 - fall0 != 2 * HT) begin errors++; $display("FAIL line_period: %0d cycles, required %0d", fall1 - fall0, 2 * HT); end
    checks++; if (vs_ticks != VSY * HT) begin errors++; $display("FAIL vs_width: %0d low ticks, required %0d", vs_ticks, VSY * HT); end
    checks++; if (blank_cnt != HV * VV) begin errors++; $display("FAIL blank_area: %0d visible ticks, required %0d", blank_cnt, HV * VV); end
  endtask

  task automatic test_ship();
    wait_px(10, 20); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL ship_top_left: rgb=%06h required %06h", rgb, C_NAVE); end
    wait_px(55, 20); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL ship_right_out: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(54, 39); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL ship_bottom_right: rgb=%06h required %06h", rgb, C_NAVE); end
    wait_px(10, 40); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL ship_below_out: rgb=%06h required %06h", rgb, C_FUNDO); end
  endtask

  // mid-frame input change must not show until the next frame
  task automatic test_snapshot();
    wait_px(0, 10);
    x_nave = 10'd30;
    x_bola_aliada = 10'd20; y_bola_aliada = 10'd10; raio_bola_aliada = 10'd5;
    x_bola_inimiga = 10'd70; y_bola_inimiga = 10'd15; raio_bola_inimiga = 10'd3;
    inimigo_x[29:20] = 10'd60; inimigo_y[29:20] = 10'd5; inimigo_vivo = 5'b00100;
    wait_px(23, 14); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL snap_shot_early: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(12, 25); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL snap_ship_old: rgb=%06h required %06h", rgb, C_NAVE); end
    wait_px(70, 25); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL snap_ship_new_early: rgb=%06h required %06h", rgb, C_FUNDO); end
  endtask

  task automatic test_shots_enemies();
    wait_px(60, 5);  checks++; if (rgb !== C_INIM) begin errors++; $display("FAIL enemy2_corner: rgb=%06h required %06h", rgb, C_INIM); end
    wait_px(23, 14); checks++; if (rgb !== C_BA) begin errors++; $display("FAIL allied_edge_in: rgb=%06h required %06h", rgb, C_BA); end
    wait_px(24, 14); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL allied_edge_out: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(70, 15); checks++; if (rgb !== C_BI) begin errors++; $display("FAIL enemy_shot_centre: rgb=%06h required %06h", rgb, C_BI); end
    wait_px(74, 15); checks++; if (rgb !== C_INIM) begin errors++; $display("FAIL enemy_shot_outside: rgb=%06h required %06h", rgb, C_INIM); end
    wait_px(12, 25); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL snap_ship_old_gone: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(30, 25); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL snap_ship_new: rgb=%06h required %06h", rgb, C_NAVE); end
    wait_px(74, 39); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL snap_ship_new_corner: rgb=%06h required %06h", rgb, C_NAVE); end
    raio_bola_aliada = 10'd0; inimigo_vivo = 5'b00000;
    x_nave = 10'd60; y_nave = 10'd30;
    x_bola_inimiga = 10'd1; y_bola_inimiga = 10'd1; raio_bola_inimiga = 10'd4;
  endtask

  task automatic test_clip_clear();
    wait_px(0, 0);   checks++; if (rgb !== C_BI) begin errors++; $display("FAIL shot_near_zero: rgb=%06h required %06h", rgb, C_BI); end
    wait_px(5, 1);   checks++; if (rgb !== C_BI) begin errors++; $display("FAIL shot_r_equal: rgb=%06h required %06h", rgb, C_BI); end
    wait_px(6, 1);   checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL shot_r_over: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(60, 5);  checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL enemy2_killed: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(23, 14); checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL allied_raio0: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(0, 30);  checks++; if (rgb !== C_FUNDO) begin errors++; $display("FAIL ship_no_wrap: rgb=%06h required %06h", rgb, C_FUNDO); end
    wait_px(60, 30); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL ship_clip_left: rgb=%06h required %06h", rgb, C_NAVE); end
    wait_px(79, 30); checks++; if (rgb !== C_NAVE) begin errors++; $display("FAIL ship_clip_edge: rgb=%06h required %06h", rgb, C_NAVE); end
    set_random_inputs();
  endtask

  // one full frame of random entities against the reference model
  task automatic test_random_frame();
    bit ok;
    logic [23:0] e_rgb;
    logic e_hs, e_vs, e_bl;
    int h, v;
    wait_px(0, 0);
    for (int p = 0; p < HT * VT && !stalled; p++) begin
      h = p % HT; v = p / HT;
      e_rgb = model_rgb(h, v);
      e_hs = !(h >= HV + HF && h < HV + HF + HSY);
      e_vs = !(v >= VV + VF && v < VV + VF + VSY);
      e_bl = (h < HV) && (v < VV);
      checks++;
      if ({rgb, vga_hs, vga_vs, vga_blank_n} !== {e_rgb, e_hs, e_vs, e_bl}) begin
        errors++;
        $display("FAIL random_px(%0d,%0d): rgb=%06h hs=%b vs=%b blank_n=%b, required %06h %b %b %b",
                 h, v, rgb, vga_hs, vga_vs, vga_blank_n, e_rgb, e_hs, e_vs, e_bl);
      end
      if (p == HT * 20) set_random_inputs();
      next_tick(ok);
    end
    checks++; if (last_vs_fall - prev_vs_fall != 2 * HT * VT) begin errors++; $display("FAIL frame_period: %0d cycles, required %0d", last_vs_fall - prev_vs_fall, 2 * HT * VT); end
  endtask

  task automatic test_reset_midframe();
    repeat ($urandom_range(50, 400)) step();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({rgb, vga_hs, vga_vs, vga_blank_n, vga_clk} !== {24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs: rgb=%06h hs=%b vs=%b blank_n=%b clk=%b, required 000000 1 1 0 0", rgb, vga_hs, vga_vs, vga_blank_n, vga_clk);
    end
    release_and_flush("midreset");
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ship();
    test_snapshot();
    test_shots_enemies();
    test_clip_clear();
    test_random_frame();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
